// File: rtl/fir_coeff_loader.sv
// ---------------------------------------------------------------------------
// fir_coeff_loader
//
// Streaming coefficient writer for the FIR MAC chain. A frame of C_NUM
// signed coefficients arrives on a valid/ready stream and is collected in a
// shadow bank. After the last beat, one COMMIT cycle copies the whole shadow
// bank into the active bank in a single edge. The taps therefore never show
// a half-updated bank.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   s_valid_i    input beat valid
//   s_ready_o    loader can accept a beat (decoded from state only)
//   s_sof_i      beat carries tap 0 of a new frame
//   s_data_i     signed coefficient, C_W bits
//   coeff_out_o  active bank, tap k at [k*C_W +: C_W]
//   busy_o       high while in LOAD or COMMIT
//   load_done_o  one-cycle pulse, new bank visible on coeff_out_o
//   load_err_o   one-cycle pulse, protocol error (orphan beat or abort)
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for a start-of-frame beat, s_ready=1
//   ST_LOAD   | collecting taps 1..C_NUM-1 into the shadow bank, s_ready=1
//   ST_COMMIT | one-cycle bubble, shadow copied to active, s_ready=0
// ---------------------------------------------------------------------------
module fir_coeff_loader #(
    parameter int C_W   = 12,
    parameter int C_NUM = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic                   s_sof_i,
    input  logic [C_W-1:0]         s_data_i,
    output logic [C_NUM*C_W-1:0]   coeff_out_o,
    output logic                   busy_o,
    output logic                   load_done_o,
    output logic                   load_err_o
);

    localparam int IDX_W = $clog2(C_NUM + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(C_NUM - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [C_W-1:0]   shadow_q [C_NUM];
    logic [C_W-1:0]   active_q [C_NUM];

    logic             accept;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             commit;

    // Readiness depends on the state register only, never on s_valid_i,
    // so the source sees a stable s_ready for the whole cycle.
    assign s_ready_o = (state_q != ST_COMMIT);
    assign busy_o    = (state_q != ST_IDLE);
    assign accept    = s_valid_i && s_ready_o;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        commit  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (s_sof_i) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        idx_d   = IDX_ONE;
                        state_d = (C_NUM == 1) ? ST_COMMIT : ST_LOAD;
                    end else begin
                        // Beat without a frame to belong to: drop it.
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (s_sof_i) begin
                        // Restart: tap 0 of the new frame, older entries
                        // get overwritten as the new frame streams in.
                        wr_idx = '0;
                        idx_d  = IDX_ONE;
                        err_d  = 1'b1;
                    end else begin
                        wr_idx = idx_q;
                        idx_d  = idx_q + IDX_ONE;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end

            ST_COMMIT: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                idx_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < C_NUM; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < C_NUM; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    shadow_q[k] <= s_data_i;
                end
            end
        end
    end

    // The whole bank moves on one edge; this is the only place the active
    // bank is written outside of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < C_NUM; k++) begin
                active_q[k] <= '0;
            end
        end else if (commit) begin
            for (int k = 0; k < C_NUM; k++) begin
                active_q[k] <= shadow_q[k];
            end
        end
    end

    for (genvar g = 0; g < C_NUM; g++) begin : g_flat
        assign coeff_out_o[g*C_W +: C_W] = active_q[g];
    end

    assign load_done_o = done_q;
    assign load_err_o  = err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
module tb_fir_coeff_loader;

    localparam int C_W   = 12;
    localparam int C_NUM = 32;
    localparam int BW    = C_W * C_NUM;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_sof   = 1'b0;
    logic [C_W-1:0]  s_data  = '0;
    logic            s_ready;
    logic [BW-1:0]   coeff_out;
    logic            busy;
    logic            load_done;
    logic            load_err;

    fir_coeff_loader #(.C_W(C_W), .C_NUM(C_NUM)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready),
        .s_sof_i     (s_sof),
        .s_data_i    (s_data),
        .coeff_out_o (coeff_out),
        .busy_o      (busy),
        .load_done_o (load_done),
        .load_err_o  (load_err)
    );

    always #5 clk = ~clk;

    int            nvec = 0;
    int            nerr = 0;
    logic [BW-1:0] exp_q [$];
    int            err_exp = 0;
    logic [BW-1:0] cur_active = '0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] fill_bank(input logic [C_W-1:0] d0, input logic [C_W-1:0] drest);
        logic [BW-1:0] b;
        for (int k = 0; k < C_NUM; k++) b[k*C_W +: C_W] = (k == 0) ? d0 : drest;
        return b;
    endfunction

    // Monitor: pops the expected bank when load_done appears, pops an
    // expected error when load_err appears, and otherwise demands that the
    // active bank stays exactly where the last commit left it.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_active = '0;
            chk("rst_coeff", coeff_out, '0);
            chk("rst_ready", BW'(s_ready), BW'(1));
            chk("rst_busy", BW'(busy), '0);
            chk("rst_done", BW'(load_done), '0);
            chk("rst_err", BW'(load_err), '0);
        end else begin
            if (load_done) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_done: load_done=1 with no frame pending");
                end else begin
                    cur_active = exp_q.pop_front();
                end
            end
            chk("coeff_bank", coeff_out, cur_active);
            if (load_err) begin
                nvec++;
                if (err_exp == 0) begin
                    nerr++;
                    $display("FAIL unexpected_err: load_err=1 with none expected");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    // Called at a negedge; presents a beat and returns at the negedge that
    // follows the edge where it was accepted. s_valid is left high so beats
    // can be chained back to back.
    task automatic beat(input logic sof, input logic [C_W-1:0] d);
        int n;
        s_valid = 1'b1;
        s_sof   = sof;
        s_data  = d;
        n = 0;
        while (!s_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            nvec++;
            nerr++;
            $display("FAIL beat_timeout: s_ready stayed 0 for %0d cycles", n);
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [C_W-1:0] d0, input logic [C_W-1:0] drest);
        beat(1'b1, d0);
        for (int k = 1; k < C_NUM; k++) beat(1'b0, drest);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] ramp;
        logic [BW-1:0] alt;

        // Reset held with s_valid toggling: monitor checks all outputs.
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #2 s_valid = ~s_valid;
            s_sof  = 1'b1;
            s_data = 12'h3C3;
        end
        @(negedge clk);

        // Ramp frame: tap k = k+1, tap 31 = -5. First beat offered right at
        // reset release so the first rising edge must accept it.
        for (int k = 0; k < C_NUM - 1; k++) ramp[k*C_W +: C_W] = C_W'(k + 1);
        ramp[31*C_W +: C_W] = 12'hFFB;
        exp_q.push_back(ramp);
        #2 rst_n = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = 12'd1;
        @(negedge clk);
        chk("busy_after_first_beat", BW'(busy), BW'(1));
        for (int k = 1; k < C_NUM - 1; k++) beat(1'b0, C_W'(k + 1));
        beat(1'b0, 12'hFFB);
        chk("ramp_ready_in_commit", BW'(s_ready), '0);
        chk("ramp_busy_in_commit", BW'(busy), BW'(1));
        chk("ramp_done_not_early", BW'(load_done), '0);
        idle(1);
        chk("ramp_done_pulse", BW'(load_done), BW'(1));
        chk("ramp_tap31_signed", BW'(coeff_out[31*C_W +: C_W]), BW'(12'hFFB));
        idle(1);
        chk("ramp_done_cleared", BW'(load_done), '0);

        // Orphan beat in IDLE.
        err_exp++;
        beat(1'b0, 12'h7FF);
        s_valid = 1'b0;
        chk("orphan_err_pulse", BW'(load_err), BW'(1));
        chk("orphan_busy", BW'(busy), '0);
        idle(2);

        // Frame A, then frame B aborted after 10 beats by a fresh 0x300 frame.
        exp_q.push_back(fill_bank(12'h100, 12'h100));
        send_frame(12'h100, 12'h100);
        idle(2);
        beat(1'b1, 12'h200);
        for (int k = 1; k < 10; k++) beat(1'b0, 12'h200);
        err_exp++;
        exp_q.push_back(fill_bank(12'h300, 12'h300));
        beat(1'b1, 12'h300);
        chk("abort_err_pulse", BW'(load_err), BW'(1));
        chk("abort_keeps_a", coeff_out, fill_bank(12'h100, 12'h100));
        for (int k = 1; k < C_NUM; k++) beat(1'b0, 12'h300);
        idle(2);
        chk("abort_commit_b", coeff_out, fill_bank(12'h300, 12'h300));

        // Backpressure: next SOF beat held through COMMIT.
        exp_q.push_back(fill_bank(12'h022, 12'h022));
        send_frame(12'h022, 12'h022);
        s_sof  = 1'b1;
        s_data = 12'h5A5;
        chk("bp_ready_low", BW'(s_ready), '0);
        exp_q.push_back(fill_bank(12'h5A5, 12'h011));
        beat(1'b1, 12'h5A5);
        chk("bp_busy_load", BW'(busy), BW'(1));
        chk("bp_bank_c", coeff_out, fill_bank(12'h022, 12'h022));
        for (int k = 1; k < C_NUM; k++) beat(1'b0, 12'h011);
        idle(2);
        chk("bp_tap0", coeff_out, fill_bank(12'h5A5, 12'h011));

        // Committed 0x055 frame, then reset after 15 beats of another frame.
        exp_q.push_back(fill_bank(12'h055, 12'h055));
        send_frame(12'h055, 12'h055);
        idle(2);
        beat(1'b1, 12'h0F0);
        for (int k = 1; k < 15; k++) beat(1'b0, 12'h0F0);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_coeff", coeff_out, '0);
        chk("midrst_busy", BW'(busy), '0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Fresh frame with alternating extreme values.
        for (int k = 0; k < C_NUM; k++) alt[k*C_W +: C_W] = (k % 2 == 0) ? 12'h7FF : 12'h800;
        exp_q.push_back(alt);
        beat(1'b1, 12'h7FF);
        for (int k = 1; k < C_NUM; k++) beat(1'b0, (k % 2 == 0) ? 12'h7FF : 12'h800);
        idle(3);
        chk("fresh_after_reset", coeff_out, alt);

        chk("pending_frames", BW'(exp_q.size()), '0);
        chk("pending_errs", BW'(err_exp), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
